// File: rtl/io_port_ctrl_if.sv
// I/O port controller bus bundle: processor port bus, device drain handshake
// and peripheral input-register load port.
// master = processor/peripheral/device side, slave = io_port_ctrl.
interface io_port_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 5
);
  logic [AW-1:0] cpu_dirport;
  logic [DW-1:0] cpu_outport;
  logic          cpu_we;
  logic [DW-1:0] cpu_inport;
  logic          cpu_stall;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_wdata;
  logic          dev_valid;
  logic          dev_ready;
  logic          in_we;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  modport master (
    output cpu_dirport, cpu_outport, cpu_we, dev_ready, in_we, in_addr, in_data,
    input  cpu_inport, cpu_stall, dev_addr, dev_wdata, dev_valid
  );

  modport slave (
    input  cpu_dirport, cpu_outport, cpu_we, dev_ready, in_we, in_addr, in_data,
    output cpu_inport, cpu_stall, dev_addr, dev_wdata, dev_valid
  );
endinterface

// File: rtl/io_port_ctrl.sv
// I/O port controller: posts processor port writes into a small FIFO that is
// drained to one device over valid/ready, stalls the processor when the FIFO
// is full, and serves reads from peripheral-loaded input registers plus a
// status port at the all-ones address.
// Optional feature macro: IO_TIMEOUT_EN (watchdog that drops a stuck head entry
// and sets a sticky error flag). Without it, the drain waits forever.
// The status word is 16 bits wide, so DW is expected to be 16.
module io_port_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 5,
  parameter int DEPTH   = 4,
  parameter int NIN     = 8,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset,
  io_port_ctrl_if.slave bus
);

  localparam int            PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            IW          = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic [AW-1:0] STATUS_PORT = {AW{1'b1}};
  localparam logic [AW-1:0] NIN_LIM     = AW'(NIN);
  localparam logic [PW:0]   FULL_CNT    = (PW + 1)'(DEPTH);

`ifdef IO_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wd_cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1} state_t;
`endif

  state_t        state, state_nx;
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count, count_nx;
  logic          full, empty, is_status, push, pop, err;
  logic [DW-1:0] in_reg [NIN];
  logic [15:0]   status_word;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign is_status   = (bus.cpu_dirport == STATUS_PORT);
  assign push        = bus.cpu_we && !is_status && !full;
  assign status_word = {err, full, empty, 5'b0, 8'(count)};

  assign bus.cpu_stall = bus.cpu_we && full && !is_status;
  assign bus.dev_valid = (state == WAIT);
  // Head is only presented while valid so idle/drop cycles show zeros.
  assign bus.dev_addr  = bus.dev_valid ? fifo_addr[rd_ptr] : '0;
  assign bus.dev_wdata = bus.dev_valid ? fifo_data[rd_ptr] : '0;

  // Pop on handshake, or unconditionally while dropping a timed-out head.
  always_comb begin
    pop = (state == WAIT) && bus.dev_ready;
`ifdef IO_TIMEOUT_EN
    if (state == DROP) begin
      pop = 1'b1;
    end else begin
      pop = (state == WAIT) && bus.dev_ready;
    end
`endif
    count_nx = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  // Drain FSM next-state: leave IDLE on push, stay in WAIT while entries remain.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (push) state_nx = WAIT;
        else      state_nx = IDLE;
      end
      WAIT: begin
        if (bus.dev_ready)        state_nx = (count_nx != '0) ? WAIT : IDLE;
`ifdef IO_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) state_nx = DROP;
`endif
        else                      state_nx = WAIT;
      end
`ifdef IO_TIMEOUT_EN
      DROP: begin
        state_nx = (count_nx != '0) ? WAIT : IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_addr[wr_ptr] <= bus.cpu_dirport;
      fifo_data[wr_ptr] <= bus.cpu_outport;
    end
  end

`ifdef IO_TIMEOUT_EN
  // Watchdog: counts stalled WAIT cycles, cleared on handshake, drop or idle.
  always_ff @(posedge clk) begin
    if (reset)                                wd_cnt <= '0;
    else if ((state == WAIT) && !bus.dev_ready) wd_cnt <= (state_nx == DROP) ? '0 : wd_cnt + TW'(1);
    else                                      wd_cnt <= '0;
  end

  // Sticky error: set when a head is dropped, cleared by a write to the status port.
  always_ff @(posedge clk) begin
    if (reset)                          err <= 1'b0;
    else if (state == DROP)             err <= 1'b1;
    else if (bus.cpu_we && is_status)   err <= 1'b0;
    else                                err <= err;
  end
`else
  assign err = 1'b0;
`endif

  // Peripheral loads into input registers; out-of-range indices are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NIN; i++) in_reg[i] <= '0;
    end else if (bus.in_we && (bus.in_addr < NIN_LIM)) begin
      in_reg[bus.in_addr[IW-1:0]] <= bus.in_data;
    end
  end

  // Processor read mux: input registers, status word, or zero.
  always_comb begin
    bus.cpu_inport = '0;
    if (bus.cpu_dirport < NIN_LIM) begin
      bus.cpu_inport = in_reg[bus.cpu_dirport[IW-1:0]];
    end else if (is_status) begin
      bus.cpu_inport = DW'(status_word);
    end else begin
      bus.cpu_inport = '0;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed self-checking bench for io_port_ctrl with a scoreboard queue of
// expected device transfers (pushed when a write is accepted, popped on handshake).
module tb_io_port_ctrl;
  localparam int DW = 16;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_port_ctrl_if #(.DW(DW), .AW(AW)) ifc ();

  io_port_ctrl #(.DW(DW), .AW(AW), .DEPTH(4), .NIN(8), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int pushes = 0;
  logic [AW+DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.push_back({a, d});
    pushes++;
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 60; n++) begin
      cyc();
      if (!ifc.dev_valid && sb.size() == 0) break;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    chk({tag, "_valid"}, 32'(ifc.dev_valid), 32'd0);
  endtask

  // Scoreboard consumer: compare every device handshake against the queue head.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (!reset && ifc.dev_valid && ifc.dev_ready) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dev_addr", 32'(ifc.dev_addr), 32'(e[AW+DW-1:DW]));
        chk("dev_wdata", 32'(ifc.dev_wdata), 32'(e[DW-1:0]));
        pops++;
      end
    end
  end

  // Global time bound so the bench can never hang.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    int wcnt;
    reset           = 1'b1;
    ifc.cpu_we      = 1'b0;
    ifc.cpu_dirport = 5'd0;
    ifc.cpu_outport = 16'h0000;
    ifc.dev_ready   = 1'b0;
    ifc.in_we       = 1'b0;
    ifc.in_addr     = 5'd0;
    ifc.in_data     = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ifc.cpu_dirport = 5'd31;
    @(negedge clk);
    chk("rst_valid", 32'(ifc.dev_valid), 32'd0);
    chk("rst_stall", 32'(ifc.cpu_stall), 32'd0);
    chk("rst_addr", 32'(ifc.dev_addr), 32'd0);
    chk("rst_wdata", 32'(ifc.dev_wdata), 32'd0);
    chk("rst_status", 32'(ifc.cpu_inport), 32'h2000);

    // Single write with device ready: visible next cycle, popped that cycle.
    cyc();
    ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'd3; ifc.cpu_outport = 16'h00A5; ifc.dev_ready = 1'b1;
    expect_xfer(5'd3, 16'h00A5);
    @(negedge clk);
    chk("sw_no_passthru", 32'(ifc.dev_valid), 32'd0);
    chk("sw_stall", 32'(ifc.cpu_stall), 32'd0);
    cyc();
    ifc.cpu_we = 1'b0; ifc.cpu_dirport = 5'd31;
    @(negedge clk);
    chk("sw_valid", 32'(ifc.dev_valid), 32'd1);
    chk("sw_status_cnt1", 32'(ifc.cpu_inport), 32'h0001);
    cyc();
    @(negedge clk);
    chk("sw_status_empty", 32'(ifc.cpu_inport), 32'h2000);

    // Fill and stall.
    cyc();
    ifc.dev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'd2; ifc.cpu_outport = 16'(16'h0011 + i);
      @(negedge clk);
      chk("fill_no_stall", 32'(ifc.cpu_stall), 32'd0);
      expect_xfer(5'd2, 16'(16'h0011 + i));
      cyc();
    end
    ifc.cpu_we = 1'b0; ifc.cpu_dirport = 5'd31;
    @(negedge clk);
    chk("fill_status_full", 32'(ifc.cpu_inport), 32'h4004);
    cyc();
    ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'd2; ifc.cpu_outport = 16'h0015;
    @(negedge clk);
    chk("fill_stall", 32'(ifc.cpu_stall), 32'd1);
    cyc();
    @(negedge clk);
    chk("fill_stall_hold", 32'(ifc.cpu_stall), 32'd1);
    cyc();
    ifc.dev_ready = 1'b1;
    @(negedge clk);
    chk("fill_stall_pop_cycle", 32'(ifc.cpu_stall), 32'd1);
    cyc();
    @(negedge clk);
    chk("fill_stall_release", 32'(ifc.cpu_stall), 32'd0);
    expect_xfer(5'd2, 16'h0015);
    cyc();
    ifc.cpu_we = 1'b0; ifc.cpu_dirport = 5'd31;
    @(negedge clk);
    chk("fill_status_cnt3", 32'(ifc.cpu_inport), 32'h0003);
    wait_drain("fill_drain");

`ifdef IO_TIMEOUT_EN
    // Timeout: head dropped after 255 stalled cycles, sticky err set.
    ifc.dev_ready = 1'b0;
    ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'd7; ifc.cpu_outport = 16'h0077;
    cyc();
    ifc.cpu_we = 1'b0; ifc.cpu_dirport = 5'd31;
    wcnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ifc.dev_valid) wcnt++;
      else break;
    end
    chk("to_wait_cycles", 32'(wcnt), 32'd255);
    chk("to_drop_valid", 32'(ifc.dev_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("to_status_err", 32'(ifc.cpu_inport), 32'hA000);
    cyc();
    ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'd31;
    @(negedge clk);
    chk("to_clr_stall", 32'(ifc.cpu_stall), 32'd0);
    cyc();
    ifc.cpu_we = 1'b0;
    @(negedge clk);
    chk("to_status_clr", 32'(ifc.cpu_inport), 32'h2000);
`else
    // No watchdog: head waits indefinitely, err stays 0.
    ifc.dev_ready = 1'b0;
    ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'd7; ifc.cpu_outport = 16'h0077;
    expect_xfer(5'd7, 16'h0077);
    cyc();
    ifc.cpu_we = 1'b0; ifc.cpu_dirport = 5'd31;
    wcnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (ifc.dev_valid) wcnt++;
    end
    chk("nto_wait_cycles", 32'(wcnt), 32'd300);
    chk("nto_status", 32'(ifc.cpu_inport), 32'h0001);
    cyc();
    ifc.cpu_we = 1'b1;
    cyc();
    ifc.cpu_we = 1'b0;
    @(negedge clk);
    chk("nto_status_wr31", 32'(ifc.cpu_inport), 32'h0001);
    cyc();
    ifc.dev_ready = 1'b1;
    wait_drain("nto_drain");
`endif

    // Input registers: load, old-value read, out-of-range load/read.
    cyc();
    ifc.in_we = 1'b1; ifc.in_addr = 5'd5; ifc.in_data = 16'hBEEF; ifc.cpu_dirport = 5'd5;
    @(negedge clk);
    chk("in_same_cycle_old", 32'(ifc.cpu_inport), 32'h0000);
    cyc();
    ifc.in_addr = 5'd9; ifc.in_data = 16'h1234;
    @(negedge clk);
    chk("in_loaded", 32'(ifc.cpu_inport), 32'hBEEF);
    cyc();
    ifc.in_addr = 5'd7; ifc.in_data = 16'h7777; ifc.cpu_dirport = 5'd9;
    @(negedge clk);
    chk("in_oob_read9", 32'(ifc.cpu_inport), 32'h0000);
    cyc();
    ifc.in_we = 1'b0; ifc.cpu_dirport = 5'd1;
    @(negedge clk);
    chk("in_oob_load_ignored", 32'(ifc.cpu_inport), 32'h0000);
    cyc();
    ifc.cpu_dirport = 5'd7;
    @(negedge clk);
    chk("in_last_reg", 32'(ifc.cpu_inport), 32'h7777);
    cyc();
    ifc.cpu_dirport = 5'd8;
    @(negedge clk);
    chk("in_oob_read8", 32'(ifc.cpu_inport), 32'h0000);

    // Simultaneous push/pop at count 2 across pointer wrap.
    cyc();
    ifc.dev_ready = 1'b0;
    ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'd4; ifc.cpu_outport = 16'h00A0;
    expect_xfer(5'd4, 16'h00A0);
    cyc();
    ifc.cpu_outport = 16'h00A1;
    expect_xfer(5'd4, 16'h00A1);
    cyc();
    ifc.dev_ready = 1'b1;
    for (int i = 2; i < 14; i++) begin
      ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'(i % 8); ifc.cpu_outport = 16'(16'h00A0 + i);
      @(negedge clk);
      chk("pp_stall", 32'(ifc.cpu_stall), 32'd0);
      chk("pp_valid", 32'(ifc.dev_valid), 32'd1);
      expect_xfer(5'(i % 8), 16'(16'h00A0 + i));
      cyc();
    end
    ifc.cpu_we = 1'b0; ifc.dev_ready = 1'b0; ifc.cpu_dirport = 5'd31;
    @(negedge clk);
    chk("pp_status_cnt2", 32'(ifc.cpu_inport), 32'h0002);
    cyc();
    ifc.dev_ready = 1'b1;
    wait_drain("pp_drain");

    // Reset with entries pending: everything discarded, input registers cleared.
    ifc.dev_ready = 1'b0;
    ifc.in_we = 1'b1; ifc.in_addr = 5'd2; ifc.in_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      ifc.cpu_we = 1'b1; ifc.cpu_dirport = 5'd6; ifc.cpu_outport = 16'(16'h0001 + i);
      cyc();
      ifc.in_we = 1'b0;
    end
    ifc.cpu_we = 1'b0; ifc.cpu_dirport = 5'd31;
    @(negedge clk);
    chk("mr_pending", 32'(ifc.cpu_inport), 32'h0003);
    cyc();
    reset = 1'b1; ifc.dev_ready = 1'b1;
    cyc();
    reset = 1'b0; ifc.dev_ready = 1'b0;
    @(negedge clk);
    chk("mr_valid", 32'(ifc.dev_valid), 32'd0);
    chk("mr_status", 32'(ifc.cpu_inport), 32'h2000);
    for (int j = 0; j < 8; j++) begin
      ifc.cpu_dirport = 5'(j);
      @(negedge clk);
      chk("mr_in_reg", 32'(ifc.cpu_inport), 32'h0000);
    end

    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    chk("xfer_total", 32'(pops), 32'(pushes));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
